ahb_slave_port_mux: RTL
=======================

# ahb_slave_port_mux

Slave-side transfer multiplexer for one AHB slave port. Sits directly downstream of the per-slave arbiter. It uses the arbiter's one-hot `hgrant` to route the granted master's address/control onto the slave, and tracks the data-phase owner so that `hwdata`, `hready`, `hresp` and `hrdata` are steered correctly. It also feeds `hwait` and `hburst` back to the arbiter and keeps saturating transfer/error statistics.

## Interface
- `MASTER_NUM`, 2: number of masters connected to this slave.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `hclk`  in  1  clock; single clock domain.
- `hreset`  in  1  reset; asynchronous, active-high.
- `hgrant`  in  MASTER_NUM  one-hot grant from the arbiter; all-zero means no address-phase owner.
- `m_haddr`  in  MASTER_NUM×ADDR_W  per-master address.
- `m_htrans`  in  MASTER_NUM×2  per-master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `m_hwrite`  in  MASTER_NUM  per-master write flag.
- `m_hsize`  in  MASTER_NUM×3  per-master transfer size.
- `m_hburst`  in  MASTER_NUM×3  per-master burst type (`hburst_type` encoding).
- `m_hwdata`  in  MASTER_NUM×DATA_W  per-master write data.
- `m_hready`  out  MASTER_NUM  per-master ready.
- `m_hresp`  out  MASTER_NUM  per-master error response.
- `m_hrdata`  out  DATA_W  read data, broadcast to all masters.
- `s_hsel`, `s_haddr`, `s_htrans`, `s_hwrite`, `s_hsize`, `s_hburst`, `s_hwdata`  out  (1, ADDR_W, 2, 1, 3, 3, DATA_W)  slave-side transfer.
- `s_hreadyout`  in  1  slave ready.
- `s_hresp`  in  1  slave error.
- `s_hrdata`  in  DATA_W  slave read data.
- `arb_hwait`  out  1  to the arbiter `hwait`.
- `arb_hburst`  out  3  to the arbiter `hburst`.
- `xfer_cnt`  out  CNT_W  completed OKAY transfers, saturating.
- `err_cnt`  out  CNT_W  ERROR responses, saturating.

## Operation

Address phase (combinational):
- The address-phase mux selects the master whose `hgrant` bit is set.
- With no grant, the slave sees `s_htrans`=IDLE and `s_hsel`=0; the other slave-side outputs are 0.
- `s_hsel` = |`hgrant`.
- `arb_hburst` = `s_hburst`.
- A `hgrant` that is not one-hot is illegal. The bench flags it with an assertion. The RTL selects the lowest set index.

Data-phase tracking:
- Registers `dp_owner` (one-hot) and `dp_write` are loaded when `s_hreadyout`=1 and the state is not ERR1.
- The load value is `hgrant` if the address-phase `s_htrans` is NONSEQ or SEQ, else 0.

State machine `dp_state`:
- **IDLE**
  - Goes to ACTIVE when the load condition holds and the transfer is valid.
- **ACTIVE**
  - `s_hreadyout`=1 and `s_hresp`=0: transfer completes; `xfer_cnt`++. Next state is ACTIVE if a new valid transfer was loaded, else IDLE.
  - `s_hreadyout`=0 and `s_hresp`=1: go to ERR1.
  - `s_hreadyout`=0 and `s_hresp`=0: wait state; hold.
- **ERR1**
  - First cycle of the error response.
  - `s_htrans` is forced to IDLE so that the owner can cancel.
  - Waits for `s_hreadyout`=1 (required `s_hresp`=1), then goes to ERR2.
- **ERR2**
  - `err_cnt`++. `dp_owner` is cleared. Go to IDLE.

Data steering:
- `s_hwdata` = `m_hwdata` of `dp_owner` when `dp_write`, else 0.
- `m_hrdata` = `s_hrdata`.
- `m_hresp[i]` = `s_hresp` & `dp_owner[i]`.
- `m_hready[i]` = `s_hreadyout` if `hgrant[i]` or `dp_owner[i]`, else 0. A master that holds neither phase is stalled.
- `arb_hwait` = (state is ACTIVE/ERR1) & ~`s_hreadyout`.

Counters:
- Both counters are CNT_W wide, unsigned, and saturate at all-ones (no wrap).

Reset:
- `hreset` high asynchronously clears `dp_owner`, `dp_write`, both counters, and `dp_state`=IDLE.
- Outputs during reset: `arb_hwait`=0, `m_hresp`=0, `s_hwdata`=0.
- A reset mid-transfer abandons the data phase; no counter update occurs.

## Timing
- Address-phase routing: 0-cycle combinational from `hgrant`/`m_*` to `s_*`.
- The data-phase owner is the address owner of the previous cycle in which `s_hreadyout`=1 (1-cycle pipeline).
- `arb_hwait` is combinational from `s_hreadyout`, so the arbiter sees stalls in the same cycle.
- Counters update on the clock edge that completes the transfer (`xfer_cnt`) or the edge that enters ERR2→IDLE (`err_cnt`). They are visible 1 cycle later.
- Simultaneous cases:
  - An error completion together with a new grant: the new address phase is suppressed (IDLE) for the ERR1 cycles only. It is re-presented after ERR2.
  - A back-to-back owner change (master 0 data phase, master 1 address phase): both see `m_hready`=`s_hreadyout`.

## Test plan
- Reset asserted mid-ACTIVE write → `dp_owner`=0, `xfer_cnt` unchanged, `arb_hwait`=0 immediately (asynchronous).
- `hgrant`=2'b01, master 0 NONSEQ write to 0x100 with data 0xA5A5A5A5, `s_hreadyout`=1 → `s_haddr`=0x100 in cycle N, `s_hwdata`=0xA5A5A5A5 in N+1, `xfer_cnt`=1 at N+2.
- Slave inserts 3 wait states on master 1's read → `arb_hwait`=1 for 3 cycles, `m_hready[1]`=0 for 3 cycles, `m_hready[0]`=0, `m_hrdata`=`s_hrdata` on the completion cycle.
- Owner handover: master 0 in data phase while `hgrant`=2'b10 → `s_hwdata` comes from master 0 and `s_haddr` from master 1 in the same cycle; both `m_hready`=1.
- Two-cycle ERROR on master 0's transfer while master 1 is granted → `s_htrans`=IDLE during ERR1, `m_hresp`=2'b01 for 2 cycles, `err_cnt`=1, master 1's NONSEQ is re-issued after ERR2.
- Preload `xfer_cnt` to 0xFFFF (run 65535 transfers or force), then run one more transfer → `xfer_cnt` stays 0xFFFF.

Source files
------------

// File: rtl/ahb_slave_port_mux_if.sv
// Bus bundle around one AHB slave port: per-master request/response lanes,
// the slave-side transfer, arbiter feedback, statistics and debug state.
interface ahb_slave_port_mux_if #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
);
  // Handshake: a transfer is offered while htrans is NONSEQ/SEQ and is
  // accepted on a cycle where s_hreadyout=1; a data phase ends on the next
  // cycle with s_hreadyout=1 (OKAY) or on the second cycle of an ERROR.
  logic [MASTER_NUM-1:0]             hgrant;
  logic [MASTER_NUM-1:0][ADDR_W-1:0] m_haddr;
  logic [MASTER_NUM-1:0][1:0]        m_htrans;
  logic [MASTER_NUM-1:0]             m_hwrite;
  logic [MASTER_NUM-1:0][2:0]        m_hsize;
  logic [MASTER_NUM-1:0][2:0]        m_hburst;
  logic [MASTER_NUM-1:0][DATA_W-1:0] m_hwdata;
  logic [MASTER_NUM-1:0]             m_hready;
  logic [MASTER_NUM-1:0]             m_hresp;
  logic [DATA_W-1:0]                 m_hrdata;

  logic                              s_hsel;
  logic [ADDR_W-1:0]                 s_haddr;
  logic [1:0]                        s_htrans;
  logic                              s_hwrite;
  logic [2:0]                        s_hsize;
  logic [2:0]                        s_hburst;
  logic [DATA_W-1:0]                 s_hwdata;
  logic                              s_hreadyout;
  logic                              s_hresp;
  logic [DATA_W-1:0]                 s_hrdata;

  logic                              arb_hwait;
  logic [2:0]                        arb_hburst;
  logic [CNT_W-1:0]                  xfer_cnt;
  logic [CNT_W-1:0]                  err_cnt;

  logic [1:0]                        dbg_dp_state;
  logic [MASTER_NUM-1:0]             dbg_dp_owner;

  // The mux itself.
  modport slave (
    input  hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
    input  s_hreadyout, s_hresp, s_hrdata,
    output m_hready, m_hresp, m_hrdata,
    output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata,
    output arb_hwait, arb_hburst, xfer_cnt, err_cnt, dbg_dp_state, dbg_dp_owner
  );

  // Whatever drives the masters/slave around the mux.
  modport master (
    output hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
    output s_hreadyout, s_hresp, s_hrdata,
    input  m_hready, m_hresp, m_hrdata,
    input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata,
    input  arb_hwait, arb_hburst, xfer_cnt, err_cnt, dbg_dp_state, dbg_dp_owner
  );
endinterface

// File: rtl/ahb_slave_port_mux.sv
// Slave-port transfer mux: routes the granted master's address phase to the
// slave, tracks the data-phase owner and counts OKAY/ERROR completions.
module ahb_slave_port_mux #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
) (
  input logic                hclk,
  input logic                hreset,
  ahb_slave_port_mux_if.slave bus
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef enum logic [1:0] {
    DP_IDLE   = 2'd0,
    DP_ACTIVE = 2'd1,
    DP_ERR1   = 2'd2,
    DP_ERR2   = 2'd3
  } dp_state_t;

  dp_state_t             dp_state_q, dp_state_d;
  logic [MASTER_NUM-1:0] dp_owner_q, dp_owner_d;
  logic                  dp_write_q, dp_write_d;
  logic [CNT_W-1:0]      xfer_cnt_q, err_cnt_q;
  logic                  xfer_inc, err_inc;

  logic [MASTER_NUM-1:0] grant_oh;
  logic [ADDR_W-1:0]     a_haddr;
  logic [1:0]            a_htrans;
  logic                  a_hwrite;
  logic [2:0]            a_hsize;
  logic [2:0]            a_hburst;
  logic [1:0]            s_htrans_int;
  logic                  addr_valid;
  logic                  load_en;
  logic [DATA_W-1:0]     wdata_mux;

  // An illegal multi-hot grant collapses to its lowest set bit.
  assign grant_oh = bus.hgrant & (~bus.hgrant + MASTER_NUM'(1));

  always_comb begin
    a_haddr  = '0;
    a_htrans = HTRANS_IDLE;
    a_hwrite = 1'b0;
    a_hsize  = '0;
    a_hburst = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (grant_oh[i]) begin
        a_haddr  = bus.m_haddr[i];
        a_htrans = bus.m_htrans[i];
        a_hwrite = bus.m_hwrite[i];
        a_hsize  = bus.m_hsize[i];
        a_hburst = bus.m_hburst[i];
      end
    end
  end

  // During ERR1 the pending address phase is hidden so its owner may cancel.
  assign s_htrans_int = (dp_state_q == DP_ERR1) ? HTRANS_IDLE : a_htrans;
  assign addr_valid   = s_htrans_int[1];

  assign bus.s_hsel     = |bus.hgrant;
  assign bus.s_haddr    = a_haddr;
  assign bus.s_htrans   = s_htrans_int;
  assign bus.s_hwrite   = a_hwrite;
  assign bus.s_hsize    = a_hsize;
  assign bus.s_hburst   = a_hburst;
  assign bus.arb_hburst = a_hburst;

  // No new data phase is taken while an error response is in flight.
  assign load_en = bus.s_hreadyout &&
                   ((dp_state_q == DP_IDLE) ||
                    (dp_state_q == DP_ACTIVE && !bus.s_hresp));

  always_comb begin
    dp_state_d = dp_state_q;
    dp_owner_d = dp_owner_q;
    dp_write_d = dp_write_q;
    xfer_inc   = 1'b0;
    err_inc    = 1'b0;
    if (load_en) begin
      dp_owner_d = addr_valid ? grant_oh : '0;
      dp_write_d = addr_valid && a_hwrite;
    end
    case (dp_state_q)
      DP_IDLE: begin
        if (load_en && addr_valid) dp_state_d = DP_ACTIVE;
      end
      DP_ACTIVE: begin
        if (bus.s_hreadyout && !bus.s_hresp) begin
          xfer_inc   = 1'b1;
          dp_state_d = addr_valid ? DP_ACTIVE : DP_IDLE;
        end else if (bus.s_hresp) begin
          // A one-cycle error (ready with resp) skips straight to ERR2.
          dp_state_d = bus.s_hreadyout ? DP_ERR2 : DP_ERR1;
        end
      end
      DP_ERR1: begin
        if (bus.s_hreadyout) dp_state_d = DP_ERR2;
      end
      DP_ERR2: begin
        err_inc    = 1'b1;
        dp_owner_d = '0;
        dp_write_d = 1'b0;
        dp_state_d = DP_IDLE;
      end
      default: dp_state_d = DP_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_state_q <= DP_IDLE;
      dp_owner_q <= '0;
      dp_write_q <= 1'b0;
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      dp_state_q <= dp_state_d;
      dp_owner_q <= dp_owner_d;
      dp_write_q <= dp_write_d;
      if (xfer_inc && (xfer_cnt_q != '1)) xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
      if (err_inc && (err_cnt_q != '1))   err_cnt_q  <= err_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    wdata_mux = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (dp_owner_q[i]) wdata_mux = wdata_mux | bus.m_hwdata[i];
    end
  end

  assign bus.s_hwdata  = dp_write_q ? wdata_mux : '0;
  assign bus.m_hrdata  = bus.s_hrdata;
  assign bus.m_hresp   = dp_owner_q & {MASTER_NUM{bus.s_hresp}};
  // A master holding neither the address nor the data phase is stalled.
  assign bus.m_hready  = (bus.hgrant | dp_owner_q) & {MASTER_NUM{bus.s_hreadyout}};
  assign bus.arb_hwait = ((dp_state_q == DP_ACTIVE) || (dp_state_q == DP_ERR1)) &&
                         !bus.s_hreadyout;

  assign bus.xfer_cnt     = xfer_cnt_q;
  assign bus.err_cnt      = err_cnt_q;
  assign bus.dbg_dp_state = dp_state_q;
  assign bus.dbg_dp_owner = dp_owner_q;

endmodule
